// File: rtl/sha_pkg.sv
// Shared types, widths and message-schedule helpers for the SHA-256 round
// controller and its W-schedule sub-block.
package sha_pkg;

  localparam int WORD_W         = 32;
  localparam int BLOCK_W        = 512;
  localparam int ROUNDS_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_UPDATE,
    ST_DONE
  } state_e;

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha_w_sched.sv
// SHA-256 message schedule: 16-word sliding window holding W[t..t+15].
// Each shift presents W[t] on wt and appends W[t+16] to the window.
module sha_w_sched
  import sha_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [BLOCK_W-1:0] blk,
  output logic [WORD_W-1:0]  wt
);

  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic [WORD_W-1:0] wt_q;
  logic [WORD_W-1:0] wt_d;
  logic [WORD_W-1:0] new_w;

  always_comb begin
    new_w = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
    wt_d  = wt_q;
    for (int i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
    end
    if (load) begin
      for (int i = 0; i < 16; i++) begin
        win_d[i] = blk[BLOCK_W-1-WORD_W*i -: WORD_W];
      end
    end else if (shift) begin
      wt_d = win_q[0];
      for (int i = 0; i < 15; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[15] = new_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
      wt_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
      wt_q <= wt_d;
    end
  end

  assign wt = wt_q;

endmodule

// File: rtl/sha_round_controller.sv
// SHA-256 round sequencer: accepts 512-bit blocks and drives the compression
// core through load, ROUNDS rounds, hash update and final digest strobe.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a block; blk_ready high
//   LOAD    | core copies H into a..h (and loads IV on a message's first block)
//   ROUND   | one compression round per cycle, round_idx 0..ROUNDS-1
//   UPDATE  | core adds working vars into H
//   DONE    | digest_dv strobe after the message's last block
module sha_round_controller
  import sha_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] blk_data,
  input  logic               blk_dv,
  input  logic               blk_last,
  output logic               blk_ready,
  output logic               round_en,
  output logic [5:0]         round_idx,
  output logic [WORD_W-1:0]  wt,
  output logic               core_init,
  output logic               core_load,
  output logic               core_update,
  output logic               digest_dv,
  output logic               busy
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_e     state_q, state_d;
  logic [5:0] round_idx_q, round_idx_d;
  logic       first_blk_q, first_blk_d;
  logic       last_q, last_d;
  logic       round_en_q, round_en_d;
  logic       core_init_q, core_init_d;
  logic       core_load_q, core_load_d;
  logic       core_update_q, core_update_d;
  logic       digest_dv_q, digest_dv_d;
  logic       busy_q, busy_d;
  logic       sched_load;
  logic       sched_shift;

  always_comb begin
    state_d     = state_q;
    round_idx_d = '0;
    first_blk_d = first_blk_q;
    last_d      = last_q;
    case (state_q)
      ST_IDLE: begin
        if (blk_dv) begin
          last_d  = blk_last;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        first_blk_d = 1'b0;
        state_d     = ST_ROUND;
      end
      ST_ROUND: begin
        if (round_idx_q == LAST_IDX) begin
          state_d = ST_UPDATE;
        end else begin
          round_idx_d = round_idx_q + 6'd1;
        end
      end
      ST_UPDATE: begin
        state_d = last_q ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        first_blk_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    round_en_d    = (state_d == ST_ROUND);
    core_load_d   = (state_d == ST_LOAD);
    core_init_d   = (state_d == ST_LOAD) && first_blk_q;
    core_update_d = (state_d == ST_UPDATE);
    digest_dv_d   = (state_d == ST_DONE);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      round_idx_q   <= '0;
      first_blk_q   <= 1'b1;
      last_q        <= 1'b0;
      round_en_q    <= 1'b0;
      core_init_q   <= 1'b0;
      core_load_q   <= 1'b0;
      core_update_q <= 1'b0;
      digest_dv_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_idx_q   <= round_idx_d;
      first_blk_q   <= first_blk_d;
      last_q        <= last_d;
      round_en_q    <= round_en_d;
      core_init_q   <= core_init_d;
      core_load_q   <= core_load_d;
      core_update_q <= core_update_d;
      digest_dv_q   <= digest_dv_d;
      busy_q        <= busy_d;
    end
  end

  // Shifting on entry to each round makes wt hold W[t] during round t.
  assign sched_load  = (state_q == ST_IDLE) && blk_dv;
  assign sched_shift = (state_d == ST_ROUND);

  sha_w_sched u_w_sched (
    .clk   (clk),
    .rst   (rst),
    .load  (sched_load),
    .shift (sched_shift),
    .blk   (blk_data),
    .wt    (wt)
  );

  assign blk_ready   = (state_q == ST_IDLE) && !rst;
  assign round_en    = round_en_q;
  assign round_idx   = round_idx_q;
  assign core_init   = core_init_q;
  assign core_load   = core_load_q;
  assign core_update = core_update_q;
  assign digest_dv   = digest_dv_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sha_round_controller.sv
// Bench for sha_round_controller: a cycle-offset reference model checks every
// cycle, plus directed sequences and a known-answer table for the "abc" block.
module tb_sha_round_controller;

  typedef logic [31:0] warr_t [64];
  typedef struct {
    int          t;
    logic [31:0] w;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] blk_data;
  logic         blk_dv;
  logic         blk_last;
  logic         blk_ready;
  logic         round_en;
  logic [5:0]   round_idx;
  logic [31:0]  wt;
  logic         core_init;
  logic         core_load;
  logic         core_update;
  logic         digest_dv;
  logic         busy;

  sha_round_controller #(.ROUNDS(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .blk_data    (blk_data),
    .blk_dv      (blk_dv),
    .blk_last    (blk_last),
    .blk_ready   (blk_ready),
    .round_en    (round_en),
    .round_idx   (round_idx),
    .wt          (wt),
    .core_init   (core_init),
    .core_load   (core_load),
    .core_update (core_update),
    .digest_dv   (digest_dv),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 0;

  // Reference model: k is the cycle offset since the accepting cycle.
  bit          m_active = 0;
  bit          m_first = 1;
  bit          m_init = 0;
  int          m_k = 0;
  int          m_end = 0;
  logic [31:0] m_wt = '0;
  warr_t       m_w;

  int          acc_n = 0;
  int          acc_hist [256];
  int          cnt_load = 0, cnt_init = 0, cnt_upd = 0, cnt_dig = 0;
  int          dig_run = 0, dig_max = 0, max_idx = 0;
  int          dig_cyc_last = 0, init_load_cyc = 0;
  logic [31:0] wt_rec [64];
  vec_t        tbl [6];

  function automatic logic [31:0] bs0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] bs1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic calc_w(input logic [511:0] d, output warr_t w);
    for (int t = 0; t < 16; t++) w[t] = d[511-32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = bs1(w[t-2]) + w[t-7] + bs0(w[t-15]) + w[t-16];
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_active = 0;
      m_first  = 1;
      m_wt     = '0;
      started  = 1;
    end else if (m_active) begin
      m_k++;
      if (m_k > m_end) m_active = 0;
    end else if (blk_dv) begin
      m_active = 1;
      m_k      = 1;
      m_init   = m_first;
      m_first  = blk_last;
      m_end    = blk_last ? 67 : 66;
      calc_w(blk_data, m_w);
      acc_hist[acc_n % 256] = cyc;
      acc_n++;
    end
    if (m_active && m_k >= 2 && m_k <= 65) m_wt = m_w[m_k-2];
  endtask

  task automatic tick();
    logic [5:0] e_ctrl;
    bit         e_round;
    #1;
    if (started) chk("blk_ready", blk_ready, !m_active && !rst);
    model_step();
    @(posedge clk);
    cyc++;
    #1;
    if (started) begin
      e_round = m_active && m_k >= 2 && m_k <= 65;
      e_ctrl  = {e_round, m_active && m_k == 1 && m_init, m_active && m_k == 1,
                 m_active && m_k == 66, m_active && m_k == 67, m_active};
      chk("ctrl{round_en,init,load,update,digest,busy}",
          {round_en, core_init, core_load, core_update, digest_dv, busy}, e_ctrl);
      chk("round_idx", round_idx, e_round ? m_k - 2 : 0);
      chk("wt", wt, m_wt);
      if (core_load) cnt_load++;
      if (core_init) cnt_init++;
      if (core_init && core_load) init_load_cyc = cyc;
      if (core_update) cnt_upd++;
      if (digest_dv) begin
        cnt_dig++;
        dig_cyc_last = cyc;
        dig_run++;
      end else begin
        dig_run = 0;
      end
      if (dig_run > dig_max) dig_max = dig_run;
      if (round_en) begin
        wt_rec[round_idx] = wt;
        if (int'(round_idx) > max_idx) max_idx = int'(round_idx);
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!blk_ready && n < 200) begin
      tick();
      n++;
    end
    chk("wait_ready", blk_ready, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !blk_ready) && n < 200) begin
      tick();
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  task automatic wait_round(input int r);
    int n = 0;
    while (!(round_en && int'(round_idx) == r) && n < 100) begin
      tick();
      n++;
    end
    chk("wait_round", round_idx, r);
  endtask

  task automatic send(input logic [511:0] d, input bit l);
    wait_ready();
    blk_data = d;
    blk_last = l;
    blk_dv   = 1'b1;
    tick();
    blk_dv   = 1'b0;
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    logic [511:0] abc, d;
    warr_t        w_exp;
    int           b0, i0, d0, u0, l0, nmis;

    tbl[0] = '{0,  32'h61626380};
    tbl[1] = '{1,  32'h00000000};
    tbl[2] = '{14, 32'h00000000};
    tbl[3] = '{15, 32'h00000018};
    tbl[4] = '{16, 32'h61626380};
    tbl[5] = '{17, 32'h000F0000};

    rst = 1'b1; blk_dv = 1'b0; blk_last = 1'b0; blk_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_ready", blk_ready, 1);

    // "abc" known-answer block
    abc = {32'h61626380, 448'h0, 32'h00000018};
    b0 = acc_n;
    send(abc, 1'b1);
    wait_idle();
    for (int i = 0; i < 6; i++) chk("abc_wt", wt_rec[tbl[i].t], tbl[i].w);
    chk("abc_init_load_at_T+1", init_load_cyc - acc_hist[b0 % 256], 1);
    chk("abc_digest_at_T+67", dig_cyc_last - acc_hist[b0 % 256], 67);

    // two-block message
    i0 = cnt_init; d0 = cnt_dig; u0 = cnt_upd;
    send(rand_blk(), 1'b0);
    wait_idle();
    chk("two_blk_no_digest_after_first", cnt_dig - d0, 0);
    send(rand_blk(), 1'b1);
    wait_idle();
    chk("two_blk_init_once", cnt_init - i0, 1);
    chk("two_blk_digest_once", cnt_dig - d0, 1);
    chk("two_blk_updates", cnt_upd - u0, 2);

    // blk_dv held high, non-last blocks
    b0 = acc_n;
    blk_data = rand_blk(); blk_last = 1'b0; blk_dv = 1'b1;
    repeat (3*67 + 2) tick();
    blk_dv = 1'b0;
    chk("held_accept_count", acc_n - b0, 4);
    for (int i = 0; i < 3; i++)
      chk("held_spacing", acc_hist[(b0+i+1) % 256] - acc_hist[(b0+i) % 256], 67);
    wait_idle();

    // blk_dv pulse mid-round is ignored (also finishes the open message)
    l0 = cnt_load; d0 = cnt_dig;
    d = rand_blk();
    send(d, 1'b1);
    wait_round(30);
    blk_data = ~d; blk_last = 1'b0; blk_dv = 1'b1;
    tick();
    blk_dv = 1'b0;
    wait_idle();
    chk("pulse_single_load", cnt_load - l0, 1);
    chk("pulse_last_kept", cnt_dig - d0, 1);
    calc_w(d, w_exp);
    nmis = 0;
    for (int t = 0; t < 64; t++) if (wt_rec[t] !== w_exp[t]) nmis++;
    chk("pulse_w_sequence_mismatches", nmis, 0);

    // reset at round 40 abandons the message
    d0 = cnt_dig; u0 = cnt_upd;
    send(rand_blk(), 1'b1);
    wait_round(40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst40_outputs", {round_en, core_init, core_load, core_update, digest_dv, busy}, 0);
    chk("rst40_round_idx", round_idx, 0);
    chk("rst40_wt", wt, 0);
    chk("rst40_ready", blk_ready, 1);
    repeat (80) tick();
    chk("rst40_no_update", cnt_upd - u0, 0);
    chk("rst40_no_digest", cnt_dig - d0, 0);
    i0 = cnt_init;
    send(rand_blk(), 1'b1);
    wait_idle();
    chk("rst40_next_init", cnt_init - i0, 1);

    // back-to-back single-block messages
    i0 = cnt_init; d0 = cnt_dig;
    send(rand_blk(), 1'b1);
    send(rand_blk(), 1'b1);
    wait_idle();
    chk("b2b_init_each", cnt_init - i0, 2);
    chk("b2b_digests", cnt_dig - d0, 2);

    // randomized traffic with occasional resets
    for (int n = 0; n < 2500; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      blk_dv   = ($urandom_range(0, 3) == 0);
      blk_last = $urandom_range(0, 1) == 1;
      blk_data = rand_blk();
      tick();
    end
    rst = 1'b0; blk_dv = 1'b0;
    wait_idle();

    chk("digest_width", dig_max, 1);
    chk("max_round_idx", max_idx, 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_round_controller.md
SHA_ROUND_CONTROLLER -- requirements
Module: sha_round_controller

Interface
REQ-001 SHALL have parameter: ROUNDS, default 64, number of compression rounds per 512-bit block.
REQ-002 SHALL have ports, one clock, synchronous active-high reset:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- blk_data  in  512  message block; word 0 = bits 511:480.
- blk_dv  in  1  block-valid strobe; accepted only when blk_ready=1.
- blk_last  in  1  qualifies blk_dv; block is the final block of the message.
- blk_ready  out  1  controller can accept a block.
- round_en  out  1  core performs one round this cycle.
- round_idx  out  6  current round t, 0..ROUNDS-1.
- wt  out  32  message-schedule word W_t for round_idx.
- core_init  out  1  core loads H0..H7 from the SHA-256 IV.
- core_load  out  1  core copies H0..H7 into working vars a..h.
- core_update  out  1  core performs H_i += working var.
- digest_dv  out  1  one-cycle strobe; core H registers hold the final digest.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, ROUND, UPDATE, DONE.
REQ-004 SHALL drive blk_ready = (state==IDLE) && !rst; all other outputs are registered.
REQ-005 IDLE: on blk_dv=1, SHALL capture blk_data and blk_last, then go to LOAD.
REQ-006 IDLE: with blk_dv=0, SHALL stay in IDLE.
REQ-007 SHALL ignore blk_dv outside IDLE; no capture, no state change, no error.
REQ-008 LOAD (1 cycle): core_load=1; core_init=1 in the same cycle only if first_blk=1.
REQ-009 first_blk SHALL be an internal flag: set by reset and on DONE exit, cleared on LOAD exit.
REQ-010 ROUND: exactly ROUNDS consecutive cycles with round_en=1; round_idx counts 0..ROUNDS-1 by 1 per cycle.
REQ-011 Transition ROUND->UPDATE SHALL occur after round_idx=ROUNDS-1; round_idx SHALL return to 0 there.
REQ-012 UPDATE (1 cycle): core_update=1; next state DONE if the captured last=1, else IDLE.
REQ-013 DONE (1 cycle): digest_dv=1, then IDLE.
REQ-014 Latency: blk_dv accepted at cycle T gives:
- LOAD at T+1;
- rounds 0..63 at T+2..T+65;
- UPDATE at T+66;
- digest_dv at T+67 (last block) or blk_ready=1 at T+67 (non-last block).
REQ-015 wt SHALL be valid in every round_en cycle:
- t<16: wt = word t of the captured block.
- t>=16: wt = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32.
REQ-016 sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10; 32-bit, carries discarded.
REQ-017 W storage SHALL be a 16-word shift window advancing once per round_en cycle; no 64-word array.
REQ-018 round_en, core_init, core_load, core_update and digest_dv SHALL be mutually exclusive, except core_init with core_load in LOAD.
REQ-019 wt SHALL hold its last value when round_en=0; its value is don't-care for the core there.

Reset
REQ-020 On rst=1 at any clock edge, including mid-ROUND, SHALL enter IDLE and set first_blk=1.
REQ-021 On rst=1, SHALL clear round_idx, wt, round_en, core_init, core_load, core_update, digest_dv and busy to 0.
REQ-022 A reset mid-message SHALL abandon the message: no core_update and no digest_dv for it.

Structure
REQ-023 Shared package sha_pkg SHALL hold: FSM state enum, WORD_W=32, BLOCK_W=512, ROUNDS_DEFAULT=64, and sigma0/sigma1 functions.
REQ-024 The W window and recurrence SHALL live in one sub-module, sha_w_sched, with ports:
- load, shift, blk (512), wt (32).

Verification
REQ-025 Single "abc" padded block, blk_data=0x61626380_0...0_00000018, blk_last=1, expected:
- wt = 0x61626380 at t=0, 0x00000000 at t=1..14, 0x00000018 at t=15;
- wt = 0x61626380 at t=16, 0x000F0000 at t=17;
- core_init and core_load together at T+1, digest_dv at T+67.
REQ-026 Two-block message (last=0, then last=1), expected:
- core_init only in the first LOAD;
- no digest_dv after the first UPDATE;
- digest_dv exactly once, after the second UPDATE.
REQ-027 blk_dv held high continuously, expected:
- a new block is accepted only in IDLE cycles;
- block spacing is 67 cycles;
- round_idx never exceeds 63.
REQ-028 blk_dv pulsed at round_idx=30, expected:
- pulse ignored; the captured block and W sequence are unchanged;
- no extra LOAD.
REQ-029 rst at round_idx=40, expected:
- next cycle all outputs are 0 and blk_ready=1;
- the next accepted block asserts core_init.
REQ-030 Back-to-back messages, expected:
- after DONE, the next block asserts core_init;
- digest_dv width is exactly 1 cycle.
